// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: word/line widths and the writeback-buffer tag.
package lc3b_types;

    localparam int unsigned LC3B_WORD_BITS        = 16;
    localparam int unsigned LC3B_LINE_BITS        = 128;
    localparam int unsigned LC3B_LINE_OFFSET_BITS = 4;
    localparam int unsigned LC3B_WB_TAG_BITS      = LC3B_WORD_BITS - LC3B_LINE_OFFSET_BITS;

    typedef logic [LC3B_WORD_BITS-1:0]   lc3b_word;
    typedef logic [LC3B_LINE_BITS-1:0]   lc3b_cache_line;
    typedef logic [LC3B_WB_TAG_BITS-1:0] lc3b_wb_tag;

    // Line-aligned byte address for a tag (offset bits forced to zero).
    function automatic lc3b_word wb_line_addr(input lc3b_wb_tag tag);
        return {tag, {LC3B_LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/wb_entry.sv
// Single writeback-buffer entry: valid/tag/data registers plus the tag match comparator.
module wb_entry
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [11:0]  load_tag,
    input  logic [127:0] load_data,
    input  logic [11:0]  cmp_tag,
    output logic         valid,
    output logic [11:0]  tag,
    output logic [127:0] data,
    output logic         match_c
);

    lc3b_wb_tag tag_q;

    // Load wins over clear; the controller never raises both together.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            tag_q <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            tag_q <= load_tag;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    assign tag     = tag_q;
    assign match_c = valid && (cmp_tag == tag_q);

endmodule

// File: rtl/l2_writeback_buffer.sv
// Single-entry dirty-line writeback buffer between L2 and physical memory.
// Define WB_BUFFER_FORWARD_EN to serve read hits straight from the buffer.
module l2_writeback_buffer
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         l2_read,
    input  logic         l2_write,
    input  logic [15:0]  l2_address,
    input  logic [127:0] l2_wdata,
    output logic         l2_resp,
    output logic [127:0] l2_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RESP      = 2'd1,
        S_PMEM_READ = 2'd2,
        S_DRAIN     = 2'd3
    } state_t;

    state_t         state;
    lc3b_wb_tag     req_tag_c;
    logic           load_c;
    logic           clear_c;
    logic           entry_valid;
    lc3b_wb_tag     entry_tag;
    lc3b_cache_line entry_data;
    logic           entry_match_c;
    logic           unused_addr_c;

    assign req_tag_c     = l2_address[15:LC3B_LINE_OFFSET_BITS];
    assign unused_addr_c = ^l2_address[LC3B_LINE_OFFSET_BITS-1:0];

    // Accept (or merge) a write only when the entry is free or already holds that line.
    assign load_c  = (state == S_IDLE) && l2_write && (!entry_valid || entry_match_c);
    assign clear_c = (state == S_DRAIN) && pmem_resp;

    wb_entry u_entry (
        .clk       (clk),
        .reset     (reset),
        .load      (load_c),
        .clear     (clear_c),
        .load_tag  (req_tag_c),
        .load_data (l2_wdata),
        .cmp_tag   (req_tag_c),
        .valid     (entry_valid),
        .tag       (entry_tag),
        .data      (entry_data),
        .match_c   (entry_match_c)
    );

    // FSM with registered outputs; pmem strobes track the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            l2_resp      <= 1'b0;
            l2_rdata     <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            l2_resp <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (l2_write) begin
                        if (!entry_valid || entry_match_c) begin
                            state   <= S_RESP;
                            l2_resp <= 1'b1;
                        end else begin
                            state        <= S_DRAIN;
                            pmem_write   <= 1'b1;
                            pmem_address <= wb_line_addr(entry_tag);
                            pmem_wdata   <= entry_data;
                        end
                    end else if (l2_read) begin
`ifdef WB_BUFFER_FORWARD_EN
                        if (entry_match_c) begin
                            state    <= S_RESP;
                            l2_resp  <= 1'b1;
                            l2_rdata <= entry_data;
                        end else begin
                            state        <= S_PMEM_READ;
                            pmem_read    <= 1'b1;
                            pmem_address <= wb_line_addr(req_tag_c);
                        end
`else
                        // A hit must reach memory first so the refill sees the newest data.
                        if (entry_match_c) begin
                            state        <= S_DRAIN;
                            pmem_write   <= 1'b1;
                            pmem_address <= wb_line_addr(entry_tag);
                            pmem_wdata   <= entry_data;
                        end else begin
                            state        <= S_PMEM_READ;
                            pmem_read    <= 1'b1;
                            pmem_address <= wb_line_addr(req_tag_c);
                        end
`endif
                    end else if (entry_valid) begin
                        state        <= S_DRAIN;
                        pmem_write   <= 1'b1;
                        pmem_address <= wb_line_addr(entry_tag);
                        pmem_wdata   <= entry_data;
                    end
                end
                S_PMEM_READ: begin
                    if (pmem_resp) begin
                        state     <= S_RESP;
                        l2_resp   <= 1'b1;
                        l2_rdata  <= pmem_rdata;
                        pmem_read <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (pmem_resp) begin
                        state      <= S_IDLE;
                        pmem_write <= 1'b0;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Directed self-checking bench for l2_writeback_buffer (either WB_BUFFER_FORWARD_EN build).
module tb_l2_writeback_buffer;

    logic         clk;
    logic         reset;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic         l2_resp;
    logic [127:0] l2_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int tests_run;
    int tests_failed;

    localparam logic [127:0] L11 = {16{8'h11}};
    localparam logic [127:0] L3C = {16{8'h3C}};
    localparam logic [127:0] LAA = {16{8'hAA}};
    localparam logic [127:0] L55 = {16{8'h55}};
    localparam logic [127:0] LCC = {16{8'hCC}};
    localparam logic [127:0] L0F = {16{8'h0F}};

    l2_writeback_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_address   (l2_address),
        .l2_wdata     (l2_wdata),
        .l2_resp      (l2_resp),
        .l2_rdata     (l2_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        l2_read      = 1'b0;
        l2_write     = 1'b0;
        l2_address   = 16'h0000;
        l2_wdata     = '0;
        pmem_rdata   = '0;
        pmem_resp    = 1'b0;

        // Reset state
        step();
        step();
        chk1  ("rst_l2_resp",    l2_resp,      1'b0);
        chk1  ("rst_pmem_read",  pmem_read,    1'b0);
        chk1  ("rst_pmem_write", pmem_write,   1'b0);
        chk16 ("rst_pmem_addr",  pmem_address, 16'h0000);
        chk128("rst_pmem_wdata", pmem_wdata,   128'd0);
        chk128("rst_l2_rdata",   l2_rdata,     128'd0);

        // Fill 0x1230, let it start draining, then reset mid-drain
        reset      = 1'b0;
        l2_write   = 1'b1;
        l2_address = 16'h1230;
        l2_wdata   = L11;
        step();
        chk1("a_wr_resp", l2_resp, 1'b1);
        l2_write = 1'b0;
        step();
        chk1("a_resp_pulse", l2_resp, 1'b0);
        step();
        chk1  ("a_drain_wr",   pmem_write,   1'b1);
        chk16 ("a_drain_addr", pmem_address, 16'h1230);
        chk128("a_drain_data", pmem_wdata,   L11);
        step();
        chk1("a_drain_hold", pmem_write, 1'b1);
        reset = 1'b1;
        step();
        chk1  ("a_mid_rst_resp",   l2_resp,      1'b0);
        chk1  ("a_mid_rst_pread",  pmem_read,    1'b0);
        chk1  ("a_mid_rst_pwrite", pmem_write,   1'b0);
        chk16 ("a_mid_rst_addr",   pmem_address, 16'h0000);
        chk128("a_mid_rst_wdata",  pmem_wdata,   128'd0);
        chk128("a_mid_rst_rdata",  l2_rdata,     128'd0);
        reset      = 1'b0;
        l2_read    = 1'b1;
        l2_address = 16'h1230;
        step();
        chk1 ("a_rd_pread",  pmem_read,    1'b1);
        chk1 ("a_rd_pwrite", pmem_write,   1'b0);
        chk16("a_rd_addr",   pmem_address, 16'h1230);
        pmem_resp  = 1'b1;
        pmem_rdata = L3C;
        step();
        pmem_resp = 1'b0;
        l2_read   = 1'b0;
        chk1  ("a_rd_resp",  l2_resp,   1'b1);
        chk128("a_rd_data",  l2_rdata,  L3C);
        chk1  ("a_rd_pdone", pmem_read, 1'b0);
        step();
        chk1("a_rd_idle", l2_resp, 1'b0);

        // Write into empty buffer, then idle drain
        l2_write   = 1'b1;
        l2_address = 16'h4A50;
        l2_wdata   = LAA;
        step();
        chk1("b_wr_resp", l2_resp, 1'b1);
        l2_write = 1'b0;
        step();
        step();
        chk1  ("b_drain_wr",   pmem_write,   1'b1);
        chk16 ("b_drain_addr", pmem_address, 16'h4A50);
        chk128("b_drain_data", pmem_wdata,   LAA);
        step();
        chk1("b_drain_hold", pmem_write, 1'b1);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk1("b_drain_done",  pmem_write,      1'b0);
        chk1("b_valid_clear", dut.entry_valid, 1'b0);
        step();
        chk1("b_idle_pread",  pmem_read,  1'b0);
        chk1("b_idle_pwrite", pmem_write, 1'b0);

        // Read hitting the buffered line (offset bits differ)
        l2_write   = 1'b1;
        l2_address = 16'h4A50;
        l2_wdata   = LAA;
        step();
        chk1("c_wr_resp", l2_resp, 1'b1);
        l2_write   = 1'b0;
        l2_read    = 1'b1;
        l2_address = 16'h4A57;
        step();
        step();
`ifdef WB_BUFFER_FORWARD_EN
        chk1  ("c_fwd_resp",   l2_resp,    1'b1);
        chk128("c_fwd_data",   l2_rdata,   LAA);
        chk1  ("c_fwd_pread",  pmem_read,  1'b0);
        chk1  ("c_fwd_pwrite", pmem_write, 1'b0);
        l2_read = 1'b0;
        step();
        step();
        chk1("c_post_drain", pmem_write, 1'b1);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
`else
        chk1 ("c_hit_drain",  pmem_write,   1'b1);
        chk16("c_hit_daddr",  pmem_address, 16'h4A50);
        chk1 ("c_hit_nopread", pmem_read,   1'b0);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk1("c_hit_ddone", pmem_write, 1'b0);
        step();
        chk1 ("c_hit_pread", pmem_read,    1'b1);
        chk16("c_hit_raddr", pmem_address, 16'h4A50);
        pmem_resp  = 1'b1;
        pmem_rdata = LAA;
        step();
        pmem_resp = 1'b0;
        l2_read   = 1'b0;
        chk1  ("c_hit_resp", l2_resp,  1'b1);
        chk128("c_hit_data", l2_rdata, LAA);
`endif
        step();
        chk1("c_idle", l2_resp, 1'b0);

        // Write to a different line while full: drain, accept, drain new line
        l2_write   = 1'b1;
        l2_address = 16'h4A50;
        l2_wdata   = LAA;
        step();
        chk1("d_wr1_resp", l2_resp, 1'b1);
        l2_write = 1'b0;
        step();
        l2_write   = 1'b1;
        l2_address = 16'h8000;
        l2_wdata   = L55;
        step();
        chk1  ("d_ev_wr",   pmem_write,   1'b1);
        chk16 ("d_ev_addr", pmem_address, 16'h4A50);
        chk128("d_ev_data", pmem_wdata,   LAA);
        chk1  ("d_ev_noresp", l2_resp,    1'b0);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk1("d_gap_pwrite", pmem_write, 1'b0);
        chk1("d_gap_resp",   l2_resp,    1'b0);
        step();
        chk1("d_wr2_resp", l2_resp, 1'b1);
        l2_write = 1'b0;
        step();
        step();
        chk1  ("d_dr2_wr",   pmem_write,   1'b1);
        chk16 ("d_dr2_addr", pmem_address, 16'h8000);
        chk128("d_dr2_data", pmem_wdata,   L55);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;

        // Write merge into the matching entry, single drain of merged data
        l2_write   = 1'b1;
        l2_address = 16'h4A50;
        l2_wdata   = LAA;
        step();
        chk1("e_wr1_resp", l2_resp, 1'b1);
        l2_write = 1'b0;
        step();
        l2_write = 1'b1;
        l2_wdata = LCC;
        step();
        chk1("e_merge_resp",   l2_resp,    1'b1);
        chk1("e_merge_nodrain", pmem_write, 1'b0);
        l2_write = 1'b0;
        step();
        step();
        chk1  ("e_dr_wr",   pmem_write,   1'b1);
        chk16 ("e_dr_addr", pmem_address, 16'h4A50);
        chk128("e_dr_data", pmem_wdata,   LCC);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk1("e_dr_valid", dut.entry_valid, 1'b0);
        step();
        chk1("e_dr_once", pmem_write, 1'b0);

        // Read miss with 5-cycle memory latency
        l2_read    = 1'b1;
        l2_address = 16'h0100;
        step();
        chk1 ("f_pread_c1", pmem_read,    1'b1);
        chk16("f_addr",     pmem_address, 16'h0100);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk1("f_pread_wait", pmem_read, 1'b1);
            chk1("f_noresp",     l2_resp,   1'b0);
        end
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = L0F;
        step();
        pmem_resp = 1'b0;
        l2_read   = 1'b0;
        chk1  ("f_resp_c6",  l2_resp,   1'b1);
        chk128("f_data",     l2_rdata,  L0F);
        chk1  ("f_pread_off", pmem_read, 1'b0);
        step();
        chk1  ("f_resp_pulse", l2_resp,  1'b0);
        chk128("f_rdata_hold", l2_rdata, L0F);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/l2_writeback_buffer.md
# l2_writeback_buffer

Single-entry dirty-line writeback buffer between the L2 cache controller/datapath and physical memory. Takes an evicted 128-bit line from L2 in one cycle, so the L2 refill read to physical memory goes first. The buffered line drains to memory whenever the L2 side is idle. L2 reads that match the buffered line are served from the buffer.

## Interface
Parameters: none. Line and address widths are fixed by `lc3b_types` (`lc3b_word` is 16 bits, `lc3b_cache_line` is 128 bits).

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `l2_read` input 1: L2 line read request. Held until `l2_resp`.
- `l2_write` input 1: L2 eviction write request. Held until `l2_resp`. Never asserted together with `l2_read`.
- `l2_address` input 16: line address. Bits [3:0] are ignored.
- `l2_wdata` input 128: evicted line.
- `l2_resp` output 1: one-cycle completion pulse.
- `l2_rdata` output 128: read line. Valid while `l2_resp` is high.
- `pmem_read` output 1: physical memory read request.
- `pmem_write` output 1: physical memory write request.
- `pmem_address` output 16: always `{addr[15:4], 4'b0000}`.
- `pmem_wdata` output 128: buffered line.
- `pmem_rdata` input 128: memory read data.
- `pmem_resp` input 1: memory completion pulse.

## Operation
- Entry state: `valid`, `buf_addr[15:4]`, `buf_data`. Match is `valid && (l2_address[15:4] == buf_addr)`.
- The FSM has four states: IDLE, RESP, PMEM_READ, DRAIN.
- IDLE, `l2_write`:
  - If `!valid` or match: load address and data, set `valid`, go to RESP. On a match the new data overwrites the old line.
  - Otherwise (valid, no match): go to DRAIN. The request stays pending and is accepted after the drain.
- IDLE, `l2_read`:
  - On a match: copy `buf_data` into the read register and go to RESP.
  - Otherwise: go to PMEM_READ.
- IDLE with no request and `valid`: go to DRAIN. With no request and `!valid`: stay in IDLE.
- PMEM_READ:
  - `pmem_read=1`, `pmem_address` comes from `l2_address`.
  - On `pmem_resp`, register `pmem_rdata` and go to RESP.
- DRAIN:
  - `pmem_write=1`, address and data come from the entry.
  - On `pmem_resp`, clear `valid` and go to IDLE.
  - A drain is never aborted. An L2 request that arrives during a drain waits.
- RESP: `l2_resp=1` for exactly one cycle, then go to IDLE. The requester drops its request in the cycle after `l2_resp`.
- A pending L2 request has priority over an idle-time drain, except when the drain is already in progress.
- Reset clears:
  - `valid` is 0 and the FSM is in IDLE.
  - All outputs are 0: `l2_resp`, `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `l2_rdata`.
  - Reset takes effect in any state, including mid-drain and mid-read. The buffered line is lost. This is acceptable only at system reset.

## Timing
- Write accept, or a forwarded read hit: request sampled at edge N, `l2_resp` high in cycle N+1.
- Miss read: `pmem_read` asserted in the cycle after the request is sampled. `l2_resp` comes one cycle after `pmem_resp`.
- Write to a full buffer with no match: the full drain time, plus one IDLE cycle, plus one RESP cycle.
- `pmem_read` and `pmem_write` are decoded from state only and are never high together.
- `l2_rdata` holds its value until the next read completes.

## Configuration
- Macro `WB_BUFFER_FORWARD_EN`:
  - Defined: a read that matches the buffered line is forwarded from the buffer.
  - Undefined: a matching read first forces DRAIN, then PMEM_READ from memory. This costs extra latency but returns the same data.
- Write merging into a matching entry is present in both builds.

## Structure
- `lc3b_types` gets two constants:
  - `LC3B_LINE_OFFSET_BITS = 4`
  - the tag type `lc3b_wb_tag` (12 bits, address [15:4]).
- The FSM state enum stays local to the block.
- One sub-module, `wb_entry`, holds the valid/address/data registers, the load/clear controls and the match comparator. The top level holds the FSM and the read-data register.

## Test plan
- Reset mid-DRAIN (`pmem_resp` withheld), with entry 0x1230 holding line 0x11…11 -> all outputs 0 next cycle. A following read of 0x1230 goes to memory.
- Write 0x4A50 / line 0xAA…AA into an empty buffer -> `l2_resp` in the next cycle. Then idle -> `pmem_write` at 0x4A50 with 0xAA…AA until `pmem_resp`, then `valid=0`.
- Buffer holds 0x4A50 -> read 0x4A57 (same line) returns 0xAA…AA one cycle later with no pmem activity. With the macro undefined, the bench sees the write to 0x4A50 then a read of 0x4A50.
- Buffer holds 0x4A50 -> write 0x8000 / 0x55…55 -> drain of 0x4A50 first, then accept, then drain of 0x8000 with 0x55…55.
- Buffer holds 0x4A50 -> write 0x4A50 / 0xCC…CC merges. The later drain writes 0xCC…CC exactly once.
- Read miss at 0x0100 with `pmem_resp` after 5 cycles, data 0x0F…0F -> `l2_resp` on the 6th cycle with 0x0F…0F.
